// File: rtl/sqrt_seq_controller.sv
// Start/done sequencer for the restoring square-root mantissa datapath.
// Moore FSM driving reg-file and ALU controls, one result bit per iteration.
module sqrt_seq_controller #(
    parameter int N_ITER = 24
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_negative,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ie,
    output logic       o_in_sel,
    output logic       o_we,
    output logic       o_oe,
    output logic [2:0] o_addr_wr,
    output logic [2:0] o_addr_rda,
    output logic [2:0] o_addr_rdb,
    output logic [1:0] o_alu_op,
    output logic [3:0] o_state
);

    localparam int CW = $clog2(N_ITER + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N_ITER);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_ONE  = 4'd2,
        S_CLRQ = 4'd3,
        S_SHQ  = 4'd4,
        S_TRY  = 4'd5,
        S_ACC  = 4'd6,
        S_INC  = 4'd7,
        S_SHR  = 4'd8,
        S_DONE = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    // Handshake: start is a level request sampled only in IDLE (no queueing);
    // done is a single-cycle pulse in DONE, with the root on read port A.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD)
                r_cnt <= N_CNT;
            else if (r_state == S_SHR && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD: w_next = S_ONE;
            S_ONE:  w_next = S_CLRQ;
            S_CLRQ: w_next = S_SHQ;
            S_SHQ:  w_next = S_TRY;
            // Non-negative trial remainder means this root bit is a 1.
            S_TRY:  w_next = i_negative ? S_SHR : S_ACC;
            S_ACC:  w_next = S_INC;
            S_INC:  w_next = S_SHR;
            S_SHR:  w_next = (r_cnt == CW'(1)) ? S_DONE : S_SHQ;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_ie       = 1'b0;
        o_in_sel   = 1'b0;
        o_we       = 1'b0;
        o_oe       = 1'b0;
        o_addr_wr  = 3'd0;
        o_addr_rda = 3'd0;
        o_addr_rdb = 3'd0;
        o_alu_op   = 2'b00;
        case (r_state)
            S_LOAD: begin
                o_busy = 1'b1; o_ie = 1'b1; o_we = 1'b1; o_addr_wr = 3'd1;
            end
            S_ONE: begin
                o_busy = 1'b1; o_ie = 1'b1; o_in_sel = 1'b1; o_we = 1'b1; o_addr_wr = 3'd6;
            end
            S_CLRQ: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd2;
                o_addr_rda = 3'd2; o_addr_rdb = 3'd2; o_alu_op = 2'b01;
            end
            S_SHQ: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd2;
                o_addr_rda = 3'd2; o_alu_op = 2'b10;
            end
            S_TRY: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd3;
                o_addr_rda = 3'd1; o_addr_rdb = 3'd2; o_alu_op = 2'b01;
            end
            S_ACC: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd1;
                o_addr_rda = 3'd3; o_alu_op = 2'b11;
            end
            S_INC: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd2;
                o_addr_rda = 3'd2; o_addr_rdb = 3'd6; o_alu_op = 2'b00;
            end
            S_SHR: begin
                o_busy = 1'b1; o_we = 1'b1; o_addr_wr = 3'd1;
                o_addr_rda = 3'd1; o_alu_op = 2'b10;
            end
            S_DONE: begin
                o_busy = 1'b1; o_done = 1'b1; o_oe = 1'b1; o_addr_rda = 3'd2;
            end
            default: ;
        endcase
    end

    assign o_state = r_state;

endmodule
